// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared types and constants for the UART receive controller.
//   rx_state_t  : configuration FSM states (RUN, WAIT_IDLE, APPLY, SETTLE)
//   rx_cfg_t    : runtime core configuration {prescale, par_en, par_typ}.
//                 The same struct holds both the pending (shadow) copy and
//                 the applied copy.
//   CFG_DEFAULT : default configuration (prescale 8, parity on, even)
// ---------------------------------------------------------------------------
package uart_rx_pkg;

  // Width of the prescale field carried in rx_cfg_t. The controller's
  // PRESCALE_W parameter defaults to this value and is expected to match it.
  localparam int CFG_PRESCALE_W = 6;

  // Prescale values the receive core supports. Other values are still
  // applied unchanged; the core's behaviour with them is undefined.
  localparam logic [CFG_PRESCALE_W-1:0] PRESCALE_X8  = CFG_PRESCALE_W'(8);
  localparam logic [CFG_PRESCALE_W-1:0] PRESCALE_X16 = CFG_PRESCALE_W'(16);
  localparam logic [CFG_PRESCALE_W-1:0] PRESCALE_X32 = CFG_PRESCALE_W'(32);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_WAIT_IDLE = 2'd1,
    ST_APPLY     = 2'd2,
    ST_SETTLE    = 2'd3
  } rx_state_t;

  typedef struct packed {
    logic [CFG_PRESCALE_W-1:0] prescale;
    logic                      par_en;
    logic                      par_typ;   // 0 = even, 1 = odd
  } rx_cfg_t;

  localparam rx_cfg_t CFG_DEFAULT = '{
    prescale: PRESCALE_X8,
    par_en:   1'b1,
    par_typ:  1'b0
  };

endpackage : uart_rx_pkg

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Small synchronous FIFO that buffers received frames for the host.
// Pointers carry an extra wrap bit so that full and empty can be told apart
// without a separate occupancy counter.
//
// Ports
//   clk, rst   : clock, synchronous active-high reset (pointers only)
//   push       : write request; accepted when not full, or when full and a
//                pop is accepted in the same cycle
//   push_data  : data written on an accepted push
//   pop        : read request; accepted when not empty
//   full       : DEPTH entries held
//   empty      : no entries held
//   drop       : push requested but refused (full and no pop this cycle)
//   rd_data    : head entry, valid while empty = 0
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic              drop,
  output logic [DATA_W-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              pop_ok;
  logic              push_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // When full, a simultaneous pop frees the slot the push writes into, so
  // both are accepted and occupancy stays unchanged.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & ~push_ok;

  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: the storage array is deliberately not reset; only the pointers
  // define what is valid, and a reset-free array maps to plain RAM/flops
  // without a wide reset fan-out.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule : uart_rx_fifo

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
// Controller beside the UART receive core. Owns the core's runtime
// configuration and applies changes only between frames, holding the core
// disabled for SETTLE_CYC cycles afterwards. Captures each completed frame
// into a FIFO for the host, flags overrun and keeps frame/error counters.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   cfg_wr                   : one-cycle config write strobe (ignored while
//                              cfg_busy = 1)
//   cfg_prescale, cfg_par_en,
//   cfg_par_typ              : requested configuration
//   cfg_busy                 : config change pending or in progress
//   core_prescale, core_par_en,
//   core_par_typ             : applied configuration driven to the core
//   core_rx_en               : 0 holds the core idle during an apply
//   rx_busy                  : core frame in progress
//   rx_data_valid, rx_p_data : core data-valid level and parallel data
//   rx_par_err, rx_stp_err   : core error levels
//   rd_valid, rd_data,
//   rd_ready                 : host read stream
//   overrun                  : sticky, a frame was dropped (FIFO full)
//   clr_status               : clears overrun, frame_cnt and err_cnt
//   frame_cnt                : frames detected, wraps
//   err_cnt                  : error events, saturates at 255
// ---------------------------------------------------------------------------
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 4,
  parameter int PRESCALE_W   = CFG_PRESCALE_W,
  parameter int PRESCALE_RST = 8,
  parameter int SETTLE_CYC   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_wr,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic                  cfg_par_en,
  input  logic                  cfg_par_typ,
  output logic                  cfg_busy,
  output logic [PRESCALE_W-1:0] core_prescale,
  output logic                  core_par_en,
  output logic                  core_par_typ,
  output logic                  core_rx_en,
  input  logic                  rx_busy,
  input  logic                  rx_data_valid,
  input  logic [DATA_W-1:0]     rx_p_data,
  input  logic                  rx_par_err,
  input  logic                  rx_stp_err,
  output logic                  rd_valid,
  output logic [DATA_W-1:0]     rd_data,
  input  logic                  rd_ready,
  output logic                  overrun,
  input  logic                  clr_status,
  output logic [15:0]           frame_cnt,
  output logic [7:0]            err_cnt
);

  localparam int CNT_W = $clog2(SETTLE_CYC + 1);

  localparam rx_cfg_t CFG_RST = '{
    prescale: CFG_PRESCALE_W'(PRESCALE_RST),
    par_en:   CFG_DEFAULT.par_en,
    par_typ:  CFG_DEFAULT.par_typ
  };

  // -------------------------------------------------------------------------
  // Configuration FSM
  // -------------------------------------------------------------------------
  rx_state_t        state;
  rx_cfg_t          shadow_cfg;
  rx_cfg_t          core_cfg;
  logic [CNT_W-1:0] settle_cnt;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the values from before the clock edge, independent of
  // statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      shadow_cfg <= CFG_RST;
      core_cfg   <= CFG_RST;
      core_rx_en <= 1'b1;
      settle_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (cfg_wr) begin
            shadow_cfg <= '{
              prescale: CFG_PRESCALE_W'(cfg_prescale),
              par_en:   cfg_par_en,
              par_typ:  cfg_par_typ
            };
            state <= ST_WAIT_IDLE;
          end
        end

        // Never change the core's configuration under a frame in flight.
        ST_WAIT_IDLE: begin
          if (!rx_busy) begin
            core_rx_en <= 1'b0;
            state      <= ST_APPLY;
          end
        end

        ST_APPLY: begin
          core_cfg   <= shadow_cfg;
          settle_cnt <= CNT_W'(SETTLE_CYC);
          state      <= ST_SETTLE;
        end

        // Leave on the last settle cycle so the core is re-enabled exactly
        // SETTLE_CYC cycles after the new values appear.
        ST_SETTLE: begin
          if (settle_cnt == CNT_W'(1)) begin
            core_rx_en <= 1'b1;
            state      <= ST_RUN;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end

        default: begin
          core_rx_en <= 1'b1;
          state      <= ST_RUN;
        end
      endcase
    end
  end

  assign cfg_busy      = (state != ST_RUN);
  assign core_prescale = PRESCALE_W'(core_cfg.prescale);
  assign core_par_en   = core_cfg.par_en;
  assign core_par_typ  = core_cfg.par_typ;

  // -------------------------------------------------------------------------
  // Edge detection on the core's level outputs
  // -------------------------------------------------------------------------
  logic dv_q;
  logic err_q;
  logic err_lvl;
  logic push;
  logic err_rise;

  assign err_lvl  = rx_par_err | rx_stp_err;
  assign push     = rx_data_valid & ~dv_q;
  assign err_rise = err_lvl & ~err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dv_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      dv_q  <= rx_data_valid;
      err_q <= err_lvl;
    end
  end

  // -------------------------------------------------------------------------
  // Frame FIFO
  // -------------------------------------------------------------------------
  logic fifo_full;
  logic fifo_empty;
  logic fifo_drop;

  uart_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (rx_p_data),
    .pop       (rd_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop),
    .rd_data   (rd_data)
  );

  assign rd_valid = ~fifo_empty;

  // -------------------------------------------------------------------------
  // Status: overrun flag and statistics. A clear in the same cycle as an
  // event wins and the event is lost.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else if (clr_status) begin
      overrun   <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (fifo_drop) begin
        overrun <= 1'b1;
      end
      // Dropped frames were still received, so they are counted too.
      if (push) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (err_rise && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  // Full status is only needed inside the FIFO for the drop decision.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule : uart_rx_ctrl

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed self-checking bench for uart_rx_ctrl with default parameters.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

  logic        clk;
  logic        rst;
  logic        cfg_wr;
  logic [5:0]  cfg_prescale;
  logic        cfg_par_en;
  logic        cfg_par_typ;
  logic        cfg_busy;
  logic [5:0]  core_prescale;
  logic        core_par_en;
  logic        core_par_typ;
  logic        core_rx_en;
  logic        rx_busy;
  logic        rx_data_valid;
  logic [7:0]  rx_p_data;
  logic        rx_par_err;
  logic        rx_stp_err;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_ready;
  logic        overrun;
  logic        clr_status;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_ctrl #(
    .DATA_W       (8),
    .DEPTH        (4),
    .PRESCALE_W   (6),
    .PRESCALE_RST (8),
    .SETTLE_CYC   (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_wr        (cfg_wr),
    .cfg_prescale  (cfg_prescale),
    .cfg_par_en    (cfg_par_en),
    .cfg_par_typ   (cfg_par_typ),
    .cfg_busy      (cfg_busy),
    .core_prescale (core_prescale),
    .core_par_en   (core_par_en),
    .core_par_typ  (core_par_typ),
    .core_rx_en    (core_rx_en),
    .rx_busy       (rx_busy),
    .rx_data_valid (rx_data_valid),
    .rx_p_data     (rx_p_data),
    .rx_par_err    (rx_par_err),
    .rx_stp_err    (rx_stp_err),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_ready      (rd_ready),
    .overrun       (overrun),
    .clr_status    (clr_status),
    .frame_cnt     (frame_cnt),
    .err_cnt       (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rx_data_valid high for one cycle, then low for one cycle.
  task automatic send_frame(input logic [7:0] d);
    rx_p_data     = d;
    rx_data_valid = 1'b1;
    tick();
    rx_data_valid = 1'b0;
    tick();
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic read_expect(input string tag, input logic [7:0] d);
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_data"},  32'(rd_data),  32'(d));
    pop_one();
  endtask

  initial begin
    logic [7:0] burst [5];
    burst = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};

    rst = 1'b1; cfg_wr = 1'b0; cfg_prescale = 6'd8; cfg_par_en = 1'b1;
    cfg_par_typ = 1'b0; rx_busy = 1'b0; rx_data_valid = 1'b0;
    rx_p_data = 8'h00; rx_par_err = 1'b0; rx_stp_err = 1'b0;
    rd_ready = 1'b0; clr_status = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // ---- reset state
    check("rst_prescale", 32'(core_prescale), 32'd8);
    check("rst_par_en",   32'(core_par_en),   32'd1);
    check("rst_par_typ",  32'(core_par_typ),  32'd0);
    check("rst_rx_en",    32'(core_rx_en),    32'd1);
    check("rst_cfg_busy", 32'(cfg_busy),      32'd0);
    check("rst_rd_valid", 32'(rd_valid),      32'd0);
    check("rst_overrun",  32'(overrun),       32'd0);
    check("rst_frames",   32'(frame_cnt),     32'd0);
    check("rst_errs",     32'(err_cnt),       32'd0);

    // ---- two frames, push latency of one cycle
    rx_p_data = 8'hA5; rx_data_valid = 1'b1;
    tick();
    check("push_lat_valid", 32'(rd_valid),  32'd1);
    check("push_lat_data",  32'(rd_data),   32'hA5);
    check("push_lat_cnt",   32'(frame_cnt), 32'd1);
    rx_data_valid = 1'b0;
    tick();
    send_frame(8'h3C);
    check("two_head",  32'(rd_data),   32'hA5);
    check("two_count", 32'(frame_cnt), 32'd2);
    pop_one();
    check("two_second", 32'(rd_data), 32'h3C);
    pop_one();
    check("two_empty", 32'(rd_valid), 32'd0);

    // ---- five frames into a 4-deep FIFO
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(burst[i]);
    check("ovr_flag",  32'(overrun),   32'd1);
    check("ovr_count", 32'(frame_cnt), 32'd5);
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    check("clr_overrun", 32'(overrun),   32'd0);
    check("clr_frames",  32'(frame_cnt), 32'd0);
    for (int i = 0; i < 4; i++) read_expect($sformatf("ovr_rd%0d", i), burst[i]);
    check("ovr_drained", 32'(rd_valid), 32'd0);

    // ---- push and pop together while full
    for (int i = 0; i < 4; i++) send_frame(8'h20 + 8'(i));
    rx_p_data = 8'h24; rx_data_valid = 1'b1; rd_ready = 1'b1;
    tick();
    rx_data_valid = 1'b0; rd_ready = 1'b0;
    tick();
    check("fullpp_ovr", 32'(overrun), 32'd0);
    for (int i = 1; i < 5; i++)
      read_expect($sformatf("fullpp_rd%0d", i), 8'h20 + 8'(i));
    check("fullpp_drained", 32'(rd_valid), 32'd0);

    // ---- clear coinciding with a frame: count lost, data kept
    clr_status = 1'b1; rx_p_data = 8'h77; rx_data_valid = 1'b1;
    tick();
    clr_status = 1'b0; rx_data_valid = 1'b0;
    check("clrpush_cnt",   32'(frame_cnt), 32'd0);
    check("clrpush_valid", 32'(rd_valid),  32'd1);
    check("clrpush_data",  32'(rd_data),   32'h77);
    pop_one();

    // ---- config write while the core is busy; cycle c is t+c
    for (int c = 0; c <= 15; c++) begin
      cfg_wr       = (c == 0) || (c == 5);
      cfg_prescale = (c == 0) ? 6'd16 : 6'd32;
      cfg_par_en   = 1'b0;
      cfg_par_typ  = (c == 5);
      rx_busy      = (c < 10);
      check($sformatf("cfg_prescale_t%0d", c), 32'(core_prescale),
            (c <= 11) ? 32'd8 : 32'd16);
      check($sformatf("cfg_par_en_t%0d", c), 32'(core_par_en),
            (c <= 11) ? 32'd1 : 32'd0);
      check($sformatf("cfg_rx_en_t%0d", c), 32'(core_rx_en),
            (c >= 11 && c <= 13) ? 32'd0 : 32'd1);
      check($sformatf("cfg_busy_t%0d", c), 32'(cfg_busy),
            (c >= 1 && c <= 13) ? 32'd1 : 32'd0);
      tick();
    end
    cfg_wr = 1'b0;
    check("cfg_ignored_typ", 32'(core_par_typ), 32'd0);

    // ---- error counter saturation
    for (int i = 0; i < 300; i++) begin
      rx_stp_err = 1'b1; tick();
      rx_stp_err = 1'b0; tick();
    end
    check("err_sat", 32'(err_cnt), 32'd255);
    rx_stp_err = 1'b1; clr_status = 1'b1;
    tick();
    rx_stp_err = 1'b0; clr_status = 1'b0;
    check("err_clr_wins", 32'(err_cnt), 32'd0);
    tick();
    rx_par_err = 1'b1; tick();
    rx_par_err = 1'b0; tick();
    check("err_par_inc", 32'(err_cnt), 32'd1);

    // ---- reset during SETTLE
    send_frame(8'h5A);
    cfg_wr = 1'b1; cfg_prescale = 6'd32; cfg_par_en = 1'b0; cfg_par_typ = 1'b1;
    tick();
    cfg_wr = 1'b0;
    check("rs_busy_t1", 32'(cfg_busy), 32'd1);
    tick();
    check("rs_rx_en_t2", 32'(core_rx_en), 32'd0);
    tick();
    check("rs_prescale_t3", 32'(core_prescale), 32'd32);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rs_prescale", 32'(core_prescale), 32'd8);
    check("rs_par_en",   32'(core_par_en),   32'd1);
    check("rs_rx_en",    32'(core_rx_en),    32'd1);
    check("rs_cfg_busy", 32'(cfg_busy),      32'd0);
    check("rs_rd_valid", 32'(rd_valid),      32'd0);
    check("rs_errs",     32'(err_cnt),       32'd0);
    tick(); tick(); tick(); tick();
    check("rs_shadow_gone", 32'(core_prescale), 32'd8);
    check("rs_idle",        32'(cfg_busy),      32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_uart_rx_ctrl
